// File: rtl/icache_pkg.sv
// Shared geometry and types for the instruction-cache refill path.
// Direct-mapped, 8 lines x 128 bits, 32-bit words.
package icache_pkg;

    localparam int WORD_W      = 32;
    localparam int LINE_W      = 128;
    localparam int OFFSET_BITS = 4;
    localparam int INDEX_BITS  = 3;
    localparam int TAG_BITS    = 25;
    localparam int LINE_ADDR_W = WORD_W - OFFSET_BITS;

    typedef logic [LINE_ADDR_W-1:0] line_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REQ,
        FILL
    } refill_state_e;

endpackage

// File: rtl/refill_line_buf.sv
// Beat counter and line assembly register for one cache-line refill.
// line_nxt already includes the beat being written this cycle.
module refill_line_buf
    import icache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int BEAT_W         = $clog2(WORDS_PER_LINE)
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             clr,
    input  logic                             we,
    input  logic [WORD_W-1:0]                wdata,
    output logic [BEAT_W-1:0]                beat,
    output logic                             last,
    output logic [WORDS_PER_LINE*WORD_W-1:0] line_nxt
);

    logic [BEAT_W-1:0]                beat_q, beat_d;
    logic [WORDS_PER_LINE*WORD_W-1:0] line_q, line_d;

    always_comb begin
        beat_d = beat_q;
        line_d = line_q;
        if (clr) begin
            beat_d = '0;
        end else if (we) begin
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                if (beat_q == BEAT_W'(k))
                    line_d[k*WORD_W +: WORD_W] = wdata;
            end
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            beat_q <= '0;
            line_q <= '0;
        end else begin
            beat_q <= beat_d;
            line_q <= line_d;
        end
    end

    assign beat     = beat_q;
    assign last     = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));
    assign line_nxt = line_d;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: stalls fetch on a miss, reads the line
// beat by beat from main memory and hands it to the cache fill port.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 16
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             fetch_valid,
    input  logic [31:0]                      fetch_addr,
    input  logic                             cache_hit,
    output logic                             stall,
    output logic                             mem_req,
    output logic [31:0]                      mem_addr,
    input  logic                             mem_ack,
    input  logic [31:0]                      mem_rdata,
    output logic                             fill_valid,
    output logic [31:0]                      fill_addr,
    output logic [WORDS_PER_LINE*WORD_W-1:0] fill_line,
    output logic [CNT_W-1:0]                 miss_count
);

    localparam int BEAT_W = $clog2(WORDS_PER_LINE);

    refill_state_e                    state_q, state_d;
    line_addr_t                       line_addr_q, line_addr_d;
    logic [CNT_W-1:0]                 miss_count_q, miss_count_d;
    logic [31:0]                      fill_addr_q, fill_addr_d;
    logic [WORDS_PER_LINE*WORD_W-1:0] fill_line_q, fill_line_d;

    logic                             buf_clr, buf_we, buf_last;
    logic [BEAT_W-1:0]                buf_beat;
    logic [WORDS_PER_LINE*WORD_W-1:0] buf_line_nxt;
    logic [OFFSET_BITS-1:0]           word_off;

    // Only the line part of the fetch address matters to the refill.
    logic unused_fetch_offset;
    assign unused_fetch_offset = ^fetch_addr[OFFSET_BITS-1:0];

    refill_line_buf #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .BEAT_W         (BEAT_W)
    ) u_buf (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (buf_clr),
        .we       (buf_we),
        .wdata    (mem_rdata),
        .beat     (buf_beat),
        .last     (buf_last),
        .line_nxt (buf_line_nxt)
    );

    assign word_off = OFFSET_BITS'({buf_beat, 2'b00});

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        miss_count_d = miss_count_q;
        fill_addr_d  = fill_addr_q;
        fill_line_d  = fill_line_q;
        buf_clr      = 1'b0;
        buf_we       = 1'b0;
        stall        = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        fill_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_valid)
                    state_d = CHECK;
            end
            CHECK: begin
                if (cache_hit) begin
                    state_d = IDLE;
                end else begin
                    stall       = 1'b1;
                    line_addr_d = fetch_addr[31:OFFSET_BITS];
                    buf_clr     = 1'b1;
                    if (miss_count_q != '1)
                        miss_count_d = miss_count_q + 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {line_addr_q, word_off};
                if (mem_ack) begin
                    buf_we = 1'b1;
                    // Capture on the last ack so the line is valid during FILL.
                    if (buf_last) begin
                        fill_addr_d = {line_addr_q, {OFFSET_BITS{1'b0}}};
                        fill_line_d = buf_line_nxt;
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                stall      = 1'b1;
                fill_valid = 1'b1;
                state_d    = CHECK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            line_addr_q  <= '0;
            miss_count_q <= '0;
            fill_addr_q  <= '0;
            fill_line_q  <= '0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            miss_count_q <= miss_count_d;
            fill_addr_q  <= fill_addr_d;
            fill_line_q  <= fill_line_d;
        end
    end

    assign fill_addr  = fill_addr_q;
    assign fill_line  = fill_line_q;
    assign miss_count = miss_count_q;

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss handler directly upstream of the direct-mapped instruction cache (8 lines x 128-bit; tag = addr[31:7], index = addr[6:4], word offset = addr[3:2]).
- Detects a fetch miss, stalls the fetch stage and reads the aligned 4-word line from 32-bit main memory over a req/ack handshake.
- Presents the assembled 128-bit line, with its line address, to the cache fill inputs, then re-checks the fetch.

Parameters:
- WORDS_PER_LINE, 4, 32-bit beats per line; beat counter width = log2(WORDS_PER_LINE).
- CNT_W, 16, width of the saturating miss counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- fetch_valid  in  1  fetch stage has a request on fetch_addr.
- fetch_addr  in  32  fetch address; held stable by upstream while stall=1.
- cache_hit  in  1  registered hit from the cache; valid in the cycle after a lookup.
- stall  out  1  freeze the fetch stage.
- mem_req  out  1  memory read request.
- mem_addr  out  32  word address of the current beat.
- mem_ack  in  1  single-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read data.
- fill_valid  out  1  one-cycle pulse; cache writes the line.
- fill_addr  out  32  line-aligned address, {line_addr[31:4],4'b0}.
- fill_line  out  128  assembled line; beat k occupies bits [32k+31:32k].
- miss_count  out  CNT_W  number of refills started; saturates at all-ones.

Behaviour:
- Reset (RST_N=0, takes effect immediately, no clock required):
  - State goes to IDLE.
  - stall=0, mem_req=0, mem_addr=0, fill_valid=0, fill_addr=0, fill_line=0, miss_count=0.
  - Beat counter and line buffer are cleared.
- State machine:
  - IDLE: stays in IDLE while fetch_valid=0. If fetch_valid=1, go to CHECK.
  - CHECK: the cache lookup result arrives this cycle.
    - cache_hit=1: go to IDLE.
    - cache_hit=0: latch line_addr = fetch_addr[31:4], clear the beat counter, increment miss_count (saturating), go to REQ.
  - REQ: mem_req=1, mem_addr = {line_addr, beat, 2'b00}.
    - No mem_ack: hold mem_req and mem_addr unchanged.
    - mem_ack=1: write mem_rdata into slot beat.
    - If beat = WORDS_PER_LINE-1, go to FILL. Otherwise increment beat and stay in REQ; mem_req stays high and mem_addr advances on the next cycle.
  - FILL: fill_valid=1 for exactly one cycle. fill_addr and fill_line are registered and held stable until the next FILL. Go to CHECK (re-lookup).
- stall output:
  - stall = (state in {REQ, FILL}) OR (state=CHECK AND cache_hit=0).
  - A hit therefore costs no stall beyond the cache's own lookup cycle.
- Refill latency: 1 (CHECK) + sum of per-beat ack waits (minimum 1 cycle each) + 1 (FILL) + 1 (re-CHECK).
- Boundary conditions:
  - mem_ack outside REQ is ignored: no state, data or counter change.
  - fetch_valid dropping mid-refill: the refill still completes and fill_valid still pulses. The controller then re-enters CHECK and returns to IDLE on hit; on a miss it refills again.
  - fetch_addr changing during stall is a protocol violation. The controller uses only the latched line_addr.
  - A miss at the re-check (e.g. the fill was overwritten) starts a new refill, and miss_count increments again.
  - Reset mid-refill: mem_req drops asynchronously and no fill_valid is issued. A partial line is discarded; the next miss restarts at beat 0.
  - miss_count at all-ones stays at all-ones.
  - Word address wrap: mem_addr never crosses the line; the beat field only occupies addr[3:2].

Decomposition:
- Package icache_pkg holds:
  - WORD_W=32, LINE_W=128, OFFSET_BITS=4, INDEX_BITS=3, TAG_BITS=25.
  - Line-address type (28 bits).
  - Refill state enum {IDLE, CHECK, REQ, FILL}.
- Sub-module refill_line_buf holds:
  - The beat counter and the 128-bit line register.
  - Per-beat write enable, last-beat flag and clear input.
  - The FSM stays in icache_refill_ctrl.

Test Plan:
- Reset: hold RST_N=0 with mem_ack toggling -> stall=0, mem_req=0, fill_valid=0, miss_count=0 throughout; all outputs are 0 even before the first CLK edge.
- Cold miss: fetch_addr=0x0000_0104, cache_hit=0; memory acks 1 cycle after each request with rdata=addr.
  - Required: mem_addr sequence 0x100, 0x104, 0x108, 0x10C.
  - Required: fill_addr=0x100, fill_line={0x10C,0x108,0x104,0x100}, a single fill_valid pulse.
  - Required: with cache_hit=1 at re-check, stall falls and miss_count=1.
- Hit path: fetch_valid=1 with cache_hit=1 in CHECK -> mem_req is never asserted and stall=0 in every cycle.
- Variable latency: ack delays of 0, 5, 2, 7 cycles -> mem_req and mem_addr are stable during each wait, the line is assembled correctly, and no extra beats are issued.
- Reset mid-refill: assert RST_N=0 after beat 2 is acked -> mem_req falls the same cycle and no fill_valid is issued. Next miss at 0x200 starts with mem_addr=0x200.
- Spurious ack and saturation: mem_ack=1 while IDLE -> no effect. With CNT_W=4, 17 consecutive misses -> miss_count=0xF.
